// File: rtl/maxpool_stream_if.sv
// Valid/ready stream bundle for the pooling engine: pixel input side and
// pooled-result output side. The engine uses the slave view; the producer
// and consumer around it use the master view.
interface maxpool_stream_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max/average pooling over a raster-ordered feature map.
// One row of partial window results is kept; a pooled value is emitted on the
// cycle after the last pixel of each window is accepted.
module maxpool_stream #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int POOL   = 2,
   parameter int SIGNED = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 mode,
   maxpool_stream_if.slave      bus
);
   localparam int LOG2P = $clog2(POOL);
   localparam int SH    = 2 * LOG2P;
   localparam int ACC_W = DATA_W + SH;
   localparam int NG    = IMG_W / POOL;
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int G_W   = (NG > 1) ? $clog2(NG) : 1;

   generate
      if ((IMG_W % POOL) != 0) begin : g_bad_img_w
         $error("maxpool_stream: IMG_W must be a multiple of POOL");
      end
      if ((IMG_H % POOL) != 0) begin : g_bad_img_h
         $error("maxpool_stream: IMG_H must be a multiple of POOL");
      end
      if (POOL < 2 || POOL > 8 || (POOL & (POOL - 1)) != 0) begin : g_bad_pool
         $error("maxpool_stream: POOL must be a power of two in 2..8");
      end
   endgenerate

   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic              r_mode;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic [ACC_W-1:0]  r_buf [NG];

   logic                    w_in_ready;
   logic                    w_accept;
   logic [G_W-1:0]          w_g;
   logic                    w_win_first;
   logic                    w_win_last;
   logic                    w_col_end;
   logic                    w_row_end;
   logic [ACC_W-1:0]        w_px;
   logic [ACC_W-1:0]        w_acc;
   logic signed [ACC_W-1:0] w_px_s;
   logic signed [ACC_W-1:0] w_acc_s;
   logic                    w_px_gt;
   logic [ACC_W-1:0]        w_max;
   logic [ACC_W-1:0]        w_sum;
   logic signed [ACC_W-1:0] w_sum_s;
   logic signed [ACC_W-1:0] w_avg_sr;
   logic [ACC_W-1:0]        w_avg;
   logic [ACC_W-1:0]        w_comb;
   logic [ACC_W-1:0]        w_res;
   logic                    w_unused;

   // Handshake: the only stall is a pending result that is not being taken.
   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready && !flush;

   // Window coordinates of the pixel currently on the input.
   assign w_g         = G_W'(r_col >> LOG2P);
   assign w_win_first = (r_col[LOG2P-1:0] == '0) && (r_row[LOG2P-1:0] == '0);
   assign w_win_last  = (r_col[LOG2P-1:0] == '1) && (r_row[LOG2P-1:0] == '1);
   assign w_col_end   = (r_col == COL_W'(IMG_W - 1));
   assign w_row_end   = (r_row == ROW_W'(IMG_H - 1));

   // Extend the pixel to accumulator width so sums of POOL*POOL pixels cannot overflow.
   assign w_px    = {{SH{(SIGNED != 0) && bus.in_data[DATA_W-1]}}, bus.in_data};
   assign w_acc   = r_buf[w_g];
   assign w_px_s  = w_px;
   assign w_acc_s = w_acc;
   assign w_px_gt = (SIGNED != 0) ? (w_px_s > w_acc_s) : (w_px > w_acc);
   assign w_max   = w_px_gt ? w_px : w_acc;
   assign w_sum   = w_acc + w_px;

   // Average divides by POOL*POOL with a shift; signed sums floor toward minus infinity.
   assign w_sum_s  = w_sum;
   assign w_avg_sr = w_sum_s >>> SH;
   assign w_avg    = (SIGNED != 0) ? w_avg_sr : (w_sum >> SH);

   assign w_comb   = r_mode ? w_sum : w_max;
   assign w_res    = r_mode ? w_avg : w_max;
   assign w_unused = &{1'b0, w_res[ACC_W-1:DATA_W]};

   // Raster counters, per-frame mode latch and the output result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_mode      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (flush) begin
         r_col       <= '0;
         r_row       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            if (r_col == '0 && r_row == '0) begin
               r_mode <= mode;
            end
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_accept && w_win_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res[DATA_W-1:0];
            r_out_last  <= w_col_end && w_row_end;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Row buffer of partial window results; the last window pixel bypasses it.
   always_ff @(posedge clk) begin
      if (w_accept && !w_win_last) begin
         r_buf[w_g] <= w_win_first ? w_px : w_comb;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream on a 4x4 map with 2x2 windows, signed
// arithmetic. Expected results are queued as window-completing pixels are
// driven and checked as the engine hands them over.
module tb_maxpool_stream;
   typedef logic [15:0] frame_t [16];
   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   logic clk;
   logic rst;
   logic flush;
   logic mode;
   int   total;
   int   bad;
   int   stall_cycles;
   exp_t q[$];

   maxpool_stream_if #(.DATA_W(16)) bus ();

   maxpool_stream #(
      .DATA_W(16), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .mode(mode), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference result of window w (0..3) of a 4x4 frame, signed pixels.
   function automatic logic [15:0] model(input frame_t px, input bit md, input int w);
      int r0, c0, v, best, sum, quo;
      r0 = (w / 2) * 2;
      c0 = (w % 2) * 2;
      best = -1000000;
      sum = 0;
      for (int dr = 0; dr < 2; dr++) begin
         for (int dc = 0; dc < 2; dc++) begin
            v = int'($signed(px[(r0 + dr) * 4 + c0 + dc]));
            sum += v;
            if (v > best) best = v;
         end
      end
      if (md) begin
         quo = sum / 4;
         if ((sum % 4) != 0 && sum < 0) quo = quo - 1;
         return 16'(quo);
      end
      return 16'(best);
   endfunction

   task automatic send(input logic [15:0] v);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      #1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      stall_cycles += n;
      total++;
      assert (n < 50) else begin
         bad++;
         $error("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
      end
      @(negedge clk);
   endtask

   // Drive pixels first..last; mode is only valid-looking on pixel 0 and flipped
   // afterwards, since mid-frame changes must be ignored.
   task automatic send_range(input frame_t px, input bit md, input int first, input int last);
      int w;
      exp_t e;
      for (int i = first; i <= last; i++) begin
         mode = (i == 0) ? md : !md;
         if (((i / 4) % 2) == 1 && ((i % 4) % 2) == 1) begin
            w   = (i / 8) * 2 + (i % 4) / 2;
            e.d = model(px, md, w);
            e.l = (w == 3);
            q.push_back(e);
         end
         send(px[i]);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid = 1'b0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_left", 16'(q.size()), 16'd0);
      repeat (2) @(negedge clk);
   endtask

   // Scoreboard: compare each handed-over result against the queue head.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
         total++;
         assert (q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_output observed=%h expected=none", bus.out_data);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            $display("out data=%h last=%0b exp_data=%h exp_last=%0b", bus.out_data, bus.out_last, e.d, e.l);
            check("out_data", bus.out_data, e.d);
            check("out_last", 16'(bus.out_last), 16'(e.l));
         end
      end
   end

   initial begin
      frame_t f_ramp, f_sa, f_sm, f_r1, f_r2;
      total = 0;
      bad = 0;
      stall_cycles = 0;
      rst = 1'b1;
      flush = 1'b0;
      mode = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;

      for (int i = 0; i < 16; i++) begin
         f_ramp[i] = 16'(i);
         f_sa[i]   = 16'(i * 3 - 20);
         f_sm[i]   = 16'h8000 + 16'(i * 5);
         f_r1[i]   = 16'($urandom);
         f_r2[i]   = 16'($urandom);
      end
      f_sa[0] = 16'hFFFF; f_sa[1] = 16'hFFFE; f_sa[4] = 16'hFFFD; f_sa[5] = 16'hFFFC;
      f_sm[0] = 16'hFFFB; f_sm[1] = 16'hFFFB; f_sm[4] = 16'hFFFD; f_sm[5] = 16'hFFFB;

      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 16'(bus.out_valid), 16'd0);
      check("rst_out_data", bus.out_data, 16'd0);
      check("rst_out_last", 16'(bus.out_last), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 16'(bus.in_ready), 16'd1);
      @(negedge clk);

      // Max, average, then max again, all back-to-back.
      send_range(f_ramp, 1'b0, 0, 15);
      send_range(f_ramp, 1'b1, 0, 15);
      send_range(f_ramp, 1'b0, 0, 15);
      check("no_stall_full_rate", 16'(stall_cycles), 16'd0);
      // Signed average and signed max, plus random frames in both modes.
      send_range(f_sa, 1'b1, 0, 15);
      send_range(f_sm, 1'b0, 0, 15);
      send_range(f_r1, 1'b1, 0, 15);
      send_range(f_r2, 1'b0, 0, 15);
      drain();

      // Backpressure with the first result pending.
      bus.out_ready = 1'b0;
      send_range(f_ramp, 1'b0, 0, 5);
      bus.in_valid = 1'b1;
      bus.in_data  = f_ramp[6];
      mode = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         check("hold_out_valid", 16'(bus.out_valid), 16'd1);
         check("hold_out_data", bus.out_data, 16'd5);
         check("hold_in_ready", 16'(bus.in_ready), 16'd0);
      end
      bus.out_ready = 1'b1;
      send_range(f_ramp, 1'b0, 6, 15);
      drain();

      // Flush after six pixels, with a pixel presented during the flush.
      send_range(f_ramp, 1'b0, 0, 5);
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 16'h7777;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_out_valid", 16'(bus.out_valid), 16'd0);
      send_range(f_ramp, 1'b0, 0, 15);
      drain();

      // Asynchronous reset while a result is pending.
      bus.out_ready = 1'b0;
      send_range(f_ramp, 1'b1, 0, 5);
      bus.in_valid = 1'b0;
      #1;
      check("pre_rst_out_valid", 16'(bus.out_valid), 16'd1);
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 16'(bus.out_valid), 16'd0);
      check("async_rst_out_data", bus.out_data, 16'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      send_range(f_ramp, 1'b0, 0, 15);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
